// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words from imem, feeds IF/ID.
// Latency: 0 cycles from imem_ready to delivery (combinational pass-through);
//          a word that lands during a freeze is held and delivered once freeze drops.
// Backpressure: freeze parks a returned word in inst_buf and suppresses requests;
//               a redirect with a fetch in flight drains that stale fetch first.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-low reset
//   freeze            IF/ID will not capture this cycle
//   brTaken, brAddr   redirect request and its target
//   imem_req/addr     fetch request; address held stable until imem_ready
//   imem_ready/rdata  fetch completion and returned word
//   PC, instruction   delivered {address+4, word}; both 0 when nothing is delivered
//   instValid         1 when PC/instruction carry a real instruction
module if_fetch_unit #(
  parameter int                   WORD_LEN = 32,
  parameter logic [WORD_LEN-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                brTaken,
  input  logic [WORD_LEN-1:0] brAddr,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic [WORD_LEN-1:0] PC,
  output logic [WORD_LEN-1:0] instruction,
  output logic                instValid
);

  localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(4);

  // FETCH: live request at pc_q.  HOLD: word parked in inst_buf_q, no request.
  // DRAIN: a fetch made stale by a redirect is still outstanding at drain_addr_q.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WORD_LEN-1:0] pc_q, pc_d;
  logic [WORD_LEN-1:0] drain_addr_q, drain_addr_d;
  logic [WORD_LEN-1:0] inst_buf_q, inst_buf_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      inst_buf_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      inst_buf_q   <= inst_buf_d;
    end
  end

  // Next-state logic; priority is brTaken > freeze > normal in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    inst_buf_d   = inst_buf_q;
    unique case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          if (brTaken) begin
            pc_d = brAddr;                 // returned word is on the wrong path
          end else if (freeze) begin
            inst_buf_d = imem_rdata;
            state_d    = S_HOLD;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end else if (brTaken) begin
          // The request cannot be withdrawn; remember its address so it stays
          // stable on imem_addr until the memory answers.
          drain_addr_d = pc_q;
          pc_d         = brAddr;
          state_d      = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (brTaken) begin
          pc_d    = brAddr;
          state_d = S_FETCH;
        end else if (!freeze) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (brTaken) pc_d = brAddr;        // latest redirect wins
        if (imem_ready) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs; everything is forced quiet while reset is asserted.
  logic deliver;

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    deliver     = 1'b0;
    instruction = '0;
    PC          = '0;
    instValid   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = rst;
        deliver  = rst && imem_ready && !brTaken && !freeze;
        if (deliver) instruction = imem_rdata;
      end
      S_HOLD: begin
        deliver = rst && !brTaken && !freeze;
        if (deliver) instruction = inst_buf_q;
      end
      S_DRAIN: begin
        imem_req  = rst;
        imem_addr = drain_addr_q;
      end
      default: ;
    endcase
    if (deliver) begin
      PC        = pc_q + PC_STEP;
      instValid = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        brTaken;
  logic [31:0] brAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] instruction;
  logic        instValid;

  int checks = 0;
  int failures = 0;

  if_fetch_unit #(.WORD_LEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .brTaken(brTaken), .brAddr(brAddr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .PC(PC), .instruction(instruction), .instValid(instValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        frz;
    logic        br;
    logic [31:0] bra;
    logic        rdy;
    logic [31:0] rdat;
    logic        ereq;
    logic        chk_addr;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] epc;
    logic [31:0] einst;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic frz, input logic br, input logic [31:0] bra,
                   input logic rdy, input logic [31:0] rdat,
                   input logic ereq, input logic chka, input logic [31:0] eaddr,
                   input logic evld, input logic [31:0] epc, input logic [31:0] einst);
    vec_t t;
    t.frz = frz; t.br = br; t.bra = bra; t.rdy = rdy; t.rdat = rdat;
    t.ereq = ereq; t.chk_addr = chka; t.eaddr = eaddr;
    t.evld = evld; t.epc = epc; t.einst = einst;
    tbl.push_back(t);
  endtask

  task automatic chk_out(input string tag, input logic ereq, input logic chka,
                         input logic [31:0] eaddr, input logic evld,
                         input logic [31:0] epc, input logic [31:0] einst);
    chk({tag, " imem_req"}, 32'(imem_req), 32'(ereq));
    if (chka) chk({tag, " imem_addr"}, imem_addr, eaddr);
    chk({tag, " instValid"}, 32'(instValid), 32'(evld));
    chk({tag, " PC"}, PC, epc);
    chk({tag, " instruction"}, instruction, einst);
  endtask

  task automatic drive(input logic frz, input logic br, input logic [31:0] bra,
                       input logic rdy, input logic [31:0] rdat);
    freeze = frz; brTaken = br; brAddr = bra; imem_ready = rdy; imem_rdata = rdat;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Behavioural reference for the randomized phase: a pending-stale flag,
  // a parked-word flag and the architectural PC.
  logic        m_held;
  logic [31:0] m_held_word;
  logic        m_stale;
  logic [31:0] m_stale_addr;
  logic [31:0] m_pc;

  initial begin
    // Fill table: starts right after reset release, memory returns addr+0x100.
    v(0,0,32'h0,1,32'h100,        1,1,32'h0,   1,32'h4,  32'h100);
    v(0,0,32'h0,1,32'h104,        1,1,32'h4,   1,32'h8,  32'h104);
    v(0,0,32'h0,1,32'h108,        1,1,32'h8,   1,32'hC,  32'h108);
    v(0,0,32'h0,1,32'h10C,        1,1,32'hC,   1,32'h10, 32'h10C);
    v(0,0,32'h0,0,32'hDEAD,       1,1,32'h10,  0,32'h0,  32'h0);   // 2-cycle memory
    v(0,0,32'h0,1,32'h110,        1,1,32'h10,  1,32'h14, 32'h110);
    v(0,0,32'h0,0,32'h0,          1,1,32'h14,  0,32'h0,  32'h0);
    v(0,0,32'h0,1,32'h114,        1,1,32'h14,  1,32'h18, 32'h114);
    v(1,0,32'h0,1,32'h20,         1,1,32'h18,  0,32'h0,  32'h0);   // frozen arrival
    v(1,0,32'h0,1,32'hBAD,        0,0,32'h0,   0,32'h0,  32'h0);   // ready ignored
    v(1,0,32'h0,0,32'h0,          0,0,32'h0,   0,32'h0,  32'h0);
    v(0,0,32'h0,1,32'hBAD,        0,0,32'h0,   1,32'h1C, 32'h20);  // unfreeze delivers buf
    v(0,0,32'h0,1,32'h11C,        1,1,32'h1C,  1,32'h20, 32'h11C);
    v(1,1,32'h80,1,32'h120,       1,1,32'h20,  0,32'h0,  32'h0);   // br+freeze+ready
    v(0,0,32'h0,1,32'h180,        1,1,32'h80,  1,32'h84, 32'h180);
    v(0,1,32'h40,0,32'h0,         1,1,32'h84,  0,32'h0,  32'h0);   // branch in flight
    v(0,0,32'h0,0,32'h0,          1,1,32'h84,  0,32'h0,  32'h0);
    v(0,0,32'h0,1,32'h184,        1,1,32'h84,  0,32'h0,  32'h0);   // stale discarded
    v(0,0,32'h0,1,32'h140,        1,1,32'h40,  1,32'h44, 32'h140);
    v(1,0,32'h0,1,32'h144,        1,1,32'h44,  0,32'h0,  32'h0);   // park
    v(1,1,32'h200,1,32'hBAD,      0,0,32'h0,   0,32'h0,  32'h0);   // branch drops parked word
    v(0,0,32'h0,1,32'h300,        1,1,32'h200, 1,32'h204,32'h300);
    v(0,1,32'h10,0,32'h0,         1,1,32'h204, 0,32'h0,  32'h0);   // drain...
    v(0,1,32'h20,1,32'h304,       1,1,32'h204, 0,32'h0,  32'h0);   // ...latest redirect wins
    v(0,0,32'h0,1,32'h120,        1,1,32'h20,  1,32'h24, 32'h120);
    v(0,1,32'hFFFFFFFC,0,32'h0,   1,1,32'h24,  0,32'h0,  32'h0);
    v(0,0,32'h0,1,32'h124,        1,1,32'h24,  0,32'h0,  32'h0);
    v(0,0,32'h0,1,32'hFC,         1,1,32'hFFFFFFFC,1,32'h0,32'hFC); // PC wraps
    v(0,1,32'h3,0,32'h0,          1,1,32'h0,   0,32'h0,  32'h0);
    v(0,0,32'h0,1,32'h100,        1,1,32'h0,   0,32'h0,  32'h0);
    v(0,0,32'h0,1,32'h103,        1,1,32'h3,   1,32'h7,  32'h103); // unaligned passes through

    // Reset state: outputs quiet even with ready and data present.
    rst = 1'b0;
    drive(0, 0, 32'h0, 1, 32'h1234);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].frz, tbl[i].br, tbl[i].bra, tbl[i].rdy, tbl[i].rdat);
      #1;
      chk_out($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].chk_addr, tbl[i].eaddr,
              tbl[i].evld, tbl[i].epc, tbl[i].einst);
      @(posedge clk); #1;
    end

    // Reset in the middle of an outstanding request at 0x24.
    do_reset();
    drive(0, 1, 32'h24, 1, 32'h100);
    #1 chk_out("rstseq redirect", 1, 1, 32'h0, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 32'h0);
    #1 chk_out("rstseq pending", 1, 1, 32'h24, 0, 0, 0);
    rst = 1'b0;
    drive(0, 0, 32'h0, 1, 32'h124);
    #1 chk_out("rstseq asserted", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
    #1 chk_out("rstseq released", 1, 1, 32'h0, 0, 0, 0);
    @(posedge clk); #1;

    // Randomized traffic against the reference model.
    do_reset();
    m_held = 0; m_held_word = 0; m_stale = 0; m_stale_addr = 0; m_pc = 32'h0;
    begin
      int          wait_left;
      logic        frz, br, rdy, ereq, fire, evld;
      logic [31:0] bra, rdat, eaddr, einst;
      wait_left = $urandom_range(0, 3);
      for (int cyc = 0; cyc < 3000; cyc++) begin
        frz  = ($urandom_range(0, 3) == 0);
        br   = ($urandom_range(0, 7) == 0);
        bra  = $urandom;
        rdat = $urandom;
        rdy  = imem_req ? (wait_left == 0) : 1'($urandom_range(0, 1));
        drive(frz, br, bra, rdy, rdat);
        #1;
        ereq  = !m_held;
        eaddr = m_stale ? m_stale_addr : m_pc;
        fire  = ereq && rdy;
        evld  = 1'b0;
        einst = 32'h0;
        if (m_held) begin
          if (!br && !frz) begin evld = 1'b1; einst = m_held_word; end
        end else if (!m_stale && fire && !br && !frz) begin
          evld = 1'b1; einst = rdat;
        end
        chk_out($sformatf("rand%0d", cyc), ereq, ereq, eaddr, evld,
                evld ? m_pc + 32'd4 : 32'h0, einst);
        // advance model
        if (m_held) begin
          if (br) begin m_held = 0; m_pc = bra; end
          else if (!frz) begin m_held = 0; m_pc = m_pc + 32'd4; end
        end else if (m_stale) begin
          if (fire) m_stale = 0;
          if (br) m_pc = bra;
        end else begin
          if (br) begin
            if (!fire) begin m_stale = 1; m_stale_addr = m_pc; end
            m_pc = bra;
          end else if (fire) begin
            if (frz) begin m_held = 1; m_held_word = rdat; end
            else m_pc = m_pc + 32'd4;
          end
        end
        // advance memory latency
        if (imem_req && rdy) wait_left = $urandom_range(0, 3);
        else if (imem_req && wait_left > 0) wait_left--;
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
